// File: rtl/collision_scheduler.sv
// rtl/collision_scheduler.sv - Pairwise oriented-box separating-axis scan over an object table
module collision_scheduler #(
  parameter int N_OBJ = 8,
  parameter int IDX_W = $clog2(N_OBJ)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_active,
  input  logic [7:0]       wr_width,
  input  logic [7:0]       wr_height,
  input  logic [31:0]      wr_pos_x,
  input  logic [31:0]      wr_pos_y,
  input  logic [15:0]      wr_u_x,
  input  logic [15:0]      wr_u_y,
  input  logic [15:0]      wr_v_x,
  input  logic [15:0]      wr_v_y,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx_a,
  output logic [IDX_W-1:0] out_idx_b,
  output logic [15:0]      hit_count
);

  typedef enum logic [2:0] {IDLE, LOAD, AX0, AX1, AX2, AX3, EMIT, DONE} state_t;
  state_t state, nxt;

  logic               act [N_OBJ];
  logic [7:0]         wid [N_OBJ];
  logic [7:0]         hgt [N_OBJ];
  logic signed [31:0] px  [N_OBJ];
  logic signed [31:0] py  [N_OBJ];
  logic signed [15:0] ux  [N_OBJ];
  logic signed [15:0] uy  [N_OBJ];
  logic signed [15:0] vx  [N_OBJ];
  logic signed [15:0] vy  [N_OBJ];

  logic [IDX_W-1:0]   ia, ib, idx_a_q, idx_b_q;
  logic signed [32:0] dx, dy;
  logic [15:0]        hits;
  logic               adv, last_pair, sep;
  logic signed [15:0] lx, ly;
  logic [63:0]        d_abs, r_sum;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = (state == EMIT);
  assign out_idx_a = idx_a_q;
  assign out_idx_b = idx_b_q;
  assign hit_count = hits;
  assign last_pair = (ia == IDX_W'(N_OBJ - 2)) && (ib == IDX_W'(N_OBJ - 1));

  // |a . b| with full precision; a is Q7.25 (or a sign-extended Q2.14), b is Q2.14
  function automatic logic [63:0] proj_abs(input logic signed [32:0] ax, input logic signed [32:0] ay,
                                           input logic signed [15:0] bx, input logic signed [15:0] by);
    logic signed [63:0] p;
    p = 64'(ax) * 64'(bx) + 64'(ay) * 64'(by);
    return (p < 0) ? 64'(-p) : 64'(p);
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_OBJ; i++) begin
        act[i] <= 1'b0;
        wid[i] <= '0;
        hgt[i] <= '0;
        px[i]  <= '0;
        py[i]  <= '0;
        ux[i]  <= '0;
        uy[i]  <= '0;
        vx[i]  <= '0;
        vy[i]  <= '0;
      end
    end else if (wr_en && !busy) begin
      act[wr_idx] <= wr_active;
      wid[wr_idx] <= wr_width;
      hgt[wr_idx] <= wr_height;
      px[wr_idx]  <= wr_pos_x;
      py[wr_idx]  <= wr_pos_y;
      ux[wr_idx]  <= wr_u_x;
      uy[wr_idx]  <= wr_u_y;
      vx[wr_idx]  <= wr_v_x;
      vy[wr_idx]  <= wr_v_y;
    end
  end

  // Projection |d.L| carries 39 fraction bits, each w*|u.L| term 28; the halving of the
  // extents folds into the scale, so separation is |d.L| > sum * 2^10.
  always_comb begin
    lx = ux[ia];
    ly = uy[ia];
    case (state)
      AX1: begin lx = vx[ia]; ly = vy[ia]; end
      AX2: begin lx = ux[ib]; ly = uy[ib]; end
      AX3: begin lx = vx[ib]; ly = vy[ib]; end
      default: ;
    endcase
    d_abs = proj_abs(dx, dy, lx, ly);
    r_sum = 64'(wid[ia]) * proj_abs(33'(ux[ia]), 33'(uy[ia]), lx, ly)
          + 64'(hgt[ia]) * proj_abs(33'(vx[ia]), 33'(vy[ia]), lx, ly)
          + 64'(wid[ib]) * proj_abs(33'(ux[ib]), 33'(uy[ib]), lx, ly)
          + 64'(hgt[ib]) * proj_abs(33'(vx[ib]), 33'(vy[ib]), lx, ly);
    sep = d_abs > (r_sum << 10);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    adv = 1'b0;
    case (state)
      IDLE: if (start) nxt = LOAD;
      LOAD: if (act[ia] && act[ib]) nxt = AX0; else adv = 1'b1;
      AX0:  if (sep) adv = 1'b1; else nxt = AX1;
      AX1:  if (sep) adv = 1'b1; else nxt = AX2;
      AX2:  if (sep) adv = 1'b1; else nxt = AX3;
      AX3:  if (sep) adv = 1'b1; else nxt = EMIT;
      EMIT: if (out_ready) adv = 1'b1;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (adv) nxt = last_pair ? DONE : LOAD;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ia      <= '0;
      ib      <= IDX_W'(1);
      dx      <= '0;
      dy      <= '0;
      idx_a_q <= '0;
      idx_b_q <= '0;
      hits    <= '0;
    end else begin
      if (state == IDLE && start) begin
        ia   <= '0;
        ib   <= IDX_W'(1);
        hits <= '0;
      end
      if (state == LOAD) begin
        dx      <= 33'(px[ib]) - 33'(px[ia]);
        dy      <= 33'(py[ib]) - 33'(py[ia]);
        idx_a_q <= ia;
        idx_b_q <= ib;
      end
      if (state == EMIT && out_ready) hits <= hits + 16'd1;
      if (adv) begin
        if (ib == IDX_W'(N_OBJ - 1)) begin
          ia <= ia + IDX_W'(1);
          ib <= ia + IDX_W'(2);
        end else begin
          ib <= ib + IDX_W'(1);
        end
      end
    end
  end

endmodule
